// File: rtl/mips_cpu_mem_arbiter.sv
// mips_cpu_mem_arbiter: shares one Avalon-style memory bus between the
// instruction-fetch and load/store ports of a MIPS core. Each access is a
// fixed IDLE -> bus state -> RESP sequence, with byte-lane steering for
// sub-word stores, load extension, alignment checking and an optional
// waitrequest timeout.
module mips_cpu_mem_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_PRIORITY = 1,
    parameter int STALL_LIMIT   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_req,
    input  logic [ADDR_WIDTH-1:0] instr_addr,
    output logic                  instr_ready,
    output logic [31:0]           instr_rdata,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [1:0]            data_size,
    input  logic                  data_unsigned,
    input  logic [31:0]           data_wdata,
    output logic                  data_ready,
    output logic [31:0]           data_rdata,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  read,
    output logic                  write,
    output logic [3:0]            byteenable,
    output logic [31:0]           writedata,
    input  logic                  waitrequest,
    input  logic [31:0]           readdata
);

    typedef enum logic [2:0] {IDLE, IREAD, DREAD, DWRITE, RESP} state_t;

    // Counter only needs to reach STALL_LIMIT-1; keep it 1 bit when disabled.
    localparam int CNT_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] STALL_LAST =
        (STALL_LIMIT > 0) ? CNT_W'(STALL_LIMIT - 1) : '0;

    state_t                state;
    logic [CNT_W-1:0]      stall_cnt;
    logic                  timed_out;

    logic                  pick_data;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [1:0]            sel_size;
    logic [3:0]            sel_be;
    logic [31:0]           sel_wdata;
    logic                  sel_misaligned;

    // Load shape captured at acceptance so extension does not depend on
    // the requester keeping its inputs stable.
    logic [1:0]            ld_lane;
    logic [1:0]            ld_size;
    logic                  ld_unsigned;
    logic [31:0]           ld_shift;
    logic [31:0]           ld_ext;

    // Data port wins a tie only when DATA_PRIORITY is set; loser stays pending.
    assign pick_data = data_req && (!instr_req || (DATA_PRIORITY != 0));

    // Timeout fires on the STALL_LIMIT-th consecutive stalled strobe cycle.
    assign timed_out = (STALL_LIMIT > 0) && waitrequest && (stall_cnt == STALL_LAST);

    // Lane decode and alignment check for the request about to be accepted
    always_comb begin
        sel_addr       = pick_data ? data_addr : instr_addr;
        sel_size       = pick_data ? data_size : 2'b10;
        sel_be         = 4'b1111;
        sel_wdata      = data_wdata;
        sel_misaligned = 1'b0;
        case (sel_size)
            2'b00: begin
                sel_be    = 4'b0001 << sel_addr[1:0];
                sel_wdata = {4{data_wdata[7:0]}};
            end
            2'b01: begin
                sel_be         = sel_addr[1] ? 4'b1100 : 4'b0011;
                sel_wdata      = {2{data_wdata[15:0]}};
                sel_misaligned = sel_addr[0];
            end
            default: sel_misaligned = |sel_addr[1:0];
        endcase
    end

    // Shift the addressed lanes down to bit 0, then sign/zero extend
    always_comb begin
        ld_shift = readdata >> {ld_lane, 3'b000};
        case (ld_size)
            2'b00:   ld_ext = ld_unsigned ? {24'b0, ld_shift[7:0]}
                                          : {{24{ld_shift[7]}}, ld_shift[7:0]};
            2'b01:   ld_ext = ld_unsigned ? {16'b0, ld_shift[15:0]}
                                          : {{16{ld_shift[15]}}, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    // Arbiter FSM with registered bus strobes and response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            read        <= 1'b0;
            write       <= 1'b0;
            instr_ready <= 1'b0;
            data_ready  <= 1'b0;
            err         <= 1'b0;
            byteenable  <= '0;
            address     <= '0;
            writedata   <= '0;
            instr_rdata <= '0;
            data_rdata  <= '0;
            stall_cnt   <= '0;
            ld_lane     <= '0;
            ld_size     <= '0;
            ld_unsigned <= 1'b0;
        end else begin
            // Ready/err are single-cycle pulses emitted only while in RESP.
            instr_ready <= 1'b0;
            data_ready  <= 1'b0;
            err         <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_req || data_req) begin
                        ld_lane     <= sel_addr[1:0];
                        ld_size     <= sel_size;
                        ld_unsigned <= data_unsigned;
                        if (sel_misaligned) begin
                            // No bus cycle: straight to an error response.
                            state <= RESP;
                            err   <= 1'b1;
                            if (pick_data) begin
                                data_ready <= 1'b1;
                                data_rdata <= '0;
                            end else begin
                                instr_ready <= 1'b1;
                                instr_rdata <= '0;
                            end
                        end else begin
                            address    <= {sel_addr[ADDR_WIDTH-1:2], 2'b00};
                            byteenable <= sel_be;
                            writedata  <= (pick_data && data_we) ? sel_wdata : '0;
                            stall_cnt  <= '0;
                            read       <= !(pick_data && data_we);
                            write      <= pick_data && data_we;
                            state      <= !pick_data ? IREAD : (data_we ? DWRITE : DREAD);
                        end
                    end
                end
                IREAD, DREAD, DWRITE: begin
                    if (!waitrequest || timed_out) begin
                        read  <= 1'b0;
                        write <= 1'b0;
                        state <= RESP;
                        err   <= timed_out;
                        if (state == IREAD) begin
                            instr_ready <= 1'b1;
                            instr_rdata <= timed_out ? '0 : readdata;
                        end else begin
                            data_ready <= 1'b1;
                            if (timed_out)
                                data_rdata <= '0;
                            else if (state == DREAD)
                                data_rdata <= ld_ext;
                        end
                    end else if (stall_cnt != '1) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// tb_mips_cpu_mem_arbiter: scenario tasks drive the two request ports and a
// scripted bus slave; a negedge monitor pops a scoreboard of expected
// responses on every ready pulse.
module tb_mips_cpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_req = 1'b0;
    logic [31:0] instr_addr = 32'h0;
    logic        instr_ready;
    logic [31:0] instr_rdata;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [31:0] data_addr = 32'h0;
    logic [1:0]  data_size = 2'b10;
    logic        data_unsigned = 1'b0;
    logic [31:0] data_wdata = 32'h0;
    logic        data_ready;
    logic [31:0] data_rdata;
    logic        err;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;

    typedef struct {
        logic        is_data;
        logic        chk_rd;
        logic [31:0] rdata;
        logic        e;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          strobe_cnt = 0;
    int          wait_target = 0;
    logic [31:0] rd_word = 32'h0;

    always #5 clk = ~clk;

    // Slave stalls the first wait_target cycles of every strobe.
    assign waitrequest = (read || write) && (strobe_cnt < wait_target);
    assign readdata    = rd_word;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        strobe_cnt <= (read || write) ? strobe_cnt + 1 : 0;
    end

    mips_cpu_mem_arbiter #(.STALL_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_ready(instr_ready), .instr_rdata(instr_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_size(data_size), .data_unsigned(data_unsigned),
        .data_wdata(data_wdata), .data_ready(data_ready), .data_rdata(data_rdata),
        .err(err), .address(address), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata),
        .waitrequest(waitrequest), .readdata(readdata)
    );

    // Response monitor: every ready pulse must match the scoreboard head
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] got;
        if (read === 1'b1 && write === 1'b1) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL strobe_exclusive read=%b write=%b required not both", read, write);
        end
        if (instr_ready === 1'b1 || data_ready === 1'b1) begin
            checks = checks + 1;
            got = data_ready ? data_rdata : instr_rdata;
            if (instr_ready === 1'b1 && data_ready === 1'b1) begin
                failures = failures + 1;
                $display("FAIL ready_exclusive both readies high at cycle %0d", cyc);
            end else if (sb.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_ready data=%b err=%b at cycle %0d", data_ready, err, cyc);
            end else begin
                e = sb.pop_front();
                if (data_ready !== e.is_data || err !== e.e || (e.chk_rd && got !== e.rdata)) begin
                    failures = failures + 1;
                    $display("FAIL sb_response data=%b err=%b rdata=%h required data=%b err=%b rdata=%h",
                             data_ready, err, got, e.is_data, e.e, e.rdata);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({read, write, instr_ready, data_ready, err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b required=00000", {read, write, instr_ready, data_ready, err});
        end
        checks++;
        if (byteenable !== 4'h0 || address !== 32'h0 || writedata !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus be=%b addr=%h wd=%h required zeros", byteenable, address, writedata);
        end
        checks++;
        if (instr_rdata !== 32'h0 || data_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata i=%h d=%h required zeros", instr_rdata, data_rdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        int start, lat, strobes;
        bit got, bad;
        wait_target = 0;
        rd_word = 32'h24020005;
        @(posedge clk); #1;
        sb.push_back('{1'b0, 1'b1, 32'h24020005, 1'b0});
        instr_addr = 32'hBFC00000;
        instr_req = 1'b1;
        start = cyc; lat = -1; strobes = 0; got = 0; bad = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (read) begin
                strobes++;
                if (address !== 32'hBFC00000 || byteenable !== 4'hF || write) bad = 1;
            end
            if (instr_ready) begin got = 1; lat = cyc - start; instr_req = 1'b0; end
        end
        checks++;
        if (lat != 2) begin failures++; $display("FAIL fetch_latency got=%0d required=2", lat); end
        checks++;
        if (strobes != 1) begin failures++; $display("FAIL fetch_strobes got=%0d required=1", strobes); end
        checks++;
        if (bad) begin failures++; $display("FAIL fetch_bus addr=%h be=%b required BFC00000/1111", address, byteenable); end
    endtask

    task automatic test_priority();
        int start, dlat, ilat;
        wait_target = 0;
        rd_word = 32'h11223344;
        @(posedge clk); #1;
        sb.push_back('{1'b1, 1'b1, 32'h11223344, 1'b0});
        sb.push_back('{1'b0, 1'b1, 32'h11223344, 1'b0});
        instr_addr = 32'h00000100; instr_req = 1'b1;
        data_addr = 32'h00002000; data_we = 1'b0; data_size = 2'b10;
        data_unsigned = 1'b0; data_req = 1'b1;
        start = cyc; dlat = -1; ilat = -1;
        for (int i = 0; i < 30 && ilat < 0; i++) begin
            @(negedge clk);
            if (data_ready)  begin dlat = cyc - start; data_req = 1'b0; end
            if (instr_ready) begin ilat = cyc - start; instr_req = 1'b0; end
        end
        checks++;
        if (dlat != 2) begin failures++; $display("FAIL prio_data_latency got=%0d required=2", dlat); end
        checks++;
        if (ilat != 5) begin failures++; $display("FAIL prio_fetch_latency got=%0d required=5", ilat); end
        instr_req = 1'b0; data_req = 1'b0;
    endtask

    task automatic test_store_byte_wait();
        int start, lat, strobes;
        bit got, bad;
        wait_target = 3;
        @(posedge clk); #1;
        sb.push_back('{1'b1, 1'b0, 32'h0, 1'b0});
        data_addr = 32'h00001003; data_we = 1'b1; data_size = 2'b00;
        data_wdata = 32'h000000AB; data_req = 1'b1;
        start = cyc; lat = -1; strobes = 0; got = 0; bad = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (read) bad = 1;
            if (write) begin
                strobes++;
                if (byteenable !== 4'b1000 || writedata !== 32'hABABABAB || address !== 32'h00001000) bad = 1;
            end
            if (data_ready) begin got = 1; lat = cyc - start; data_req = 1'b0; end
        end
        checks++;
        if (lat != 5) begin failures++; $display("FAIL sb_latency got=%0d required=5", lat); end
        checks++;
        if (strobes != 4) begin failures++; $display("FAIL sb_strobes got=%0d required=4", strobes); end
        checks++;
        if (bad) begin failures++; $display("FAIL sb_bus be=%b wd=%h addr=%h required 1000/ABABABAB/00001000", byteenable, writedata, address); end
        data_we = 1'b0;
        wait_target = 0;
    endtask

    task automatic test_stores();
        logic [31:0] s_addr [2];
        logic [1:0]  s_size [2];
        logic [31:0] s_wd   [2];
        logic [3:0]  s_be   [2];
        logic [31:0] s_bus  [2];
        int strobes;
        bit got, bad;
        s_addr[0] = 32'h2002; s_size[0] = 2'b01; s_wd[0] = 32'h1234ABCD; s_be[0] = 4'b1100; s_bus[0] = 32'hABCDABCD;
        s_addr[1] = 32'h2004; s_size[1] = 2'b10; s_wd[1] = 32'hDEADBEEF; s_be[1] = 4'b1111; s_bus[1] = 32'hDEADBEEF;
        wait_target = 0;
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1;
            sb.push_back('{1'b1, 1'b0, 32'h0, 1'b0});
            data_addr = s_addr[t]; data_size = s_size[t]; data_wdata = s_wd[t];
            data_we = 1'b1; data_req = 1'b1;
            strobes = 0; got = 0; bad = 0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (write) begin
                    strobes++;
                    if (byteenable !== s_be[t] || writedata !== s_bus[t]) bad = 1;
                end
                if (data_ready) begin got = 1; data_req = 1'b0; end
            end
            checks++;
            if (bad || strobes != 1) begin
                failures++;
                $display("FAIL store_%0d be=%b wd=%h strobes=%0d required be=%b wd=%h strobes=1",
                         t, byteenable, writedata, strobes, s_be[t], s_bus[t]);
            end
        end
        data_we = 1'b0;
    endtask

    task automatic test_loads();
        logic [31:0] l_addr [7];
        logic [1:0]  l_size [7];
        logic        l_uns  [7];
        logic [3:0]  l_be   [7];
        logic [31:0] l_exp  [7];
        int start, lat;
        bit got, bad;
        l_addr[0] = 32'h1002; l_size[0] = 2'b01; l_uns[0] = 1'b0; l_be[0] = 4'b1100; l_exp[0] = 32'hFFFF80FF;
        l_addr[1] = 32'h1002; l_size[1] = 2'b01; l_uns[1] = 1'b1; l_be[1] = 4'b1100; l_exp[1] = 32'h000080FF;
        l_addr[2] = 32'h1000; l_size[2] = 2'b01; l_uns[2] = 1'b0; l_be[2] = 4'b0011; l_exp[2] = 32'h00001234;
        l_addr[3] = 32'h1001; l_size[3] = 2'b00; l_uns[3] = 1'b0; l_be[3] = 4'b0010; l_exp[3] = 32'h00000012;
        l_addr[4] = 32'h1003; l_size[4] = 2'b00; l_uns[4] = 1'b0; l_be[4] = 4'b1000; l_exp[4] = 32'hFFFFFF80;
        l_addr[5] = 32'h1003; l_size[5] = 2'b00; l_uns[5] = 1'b1; l_be[5] = 4'b1000; l_exp[5] = 32'h00000080;
        l_addr[6] = 32'h1004; l_size[6] = 2'b10; l_uns[6] = 1'b0; l_be[6] = 4'b1111; l_exp[6] = 32'h80FF1234;
        wait_target = 0;
        rd_word = 32'h80FF1234;
        for (int t = 0; t < 7; t++) begin
            @(posedge clk); #1;
            sb.push_back('{1'b1, 1'b1, l_exp[t], 1'b0});
            data_addr = l_addr[t]; data_size = l_size[t]; data_unsigned = l_uns[t];
            data_we = 1'b0; data_req = 1'b1;
            start = cyc; lat = -1; got = 0; bad = 0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (read && (byteenable !== l_be[t] || address !== {l_addr[t][31:2], 2'b00})) bad = 1;
                if (data_ready) begin got = 1; lat = cyc - start; data_req = 1'b0; end
            end
            checks++;
            if (bad || lat != 2) begin
                failures++;
                $display("FAIL load_%0d be=%b lat=%0d required be=%b lat=2", t, byteenable, lat, l_be[t]);
            end
        end
        data_unsigned = 1'b0;
    endtask

    task automatic test_misaligned();
        logic        m_dat  [4];
        logic        m_we   [4];
        logic [31:0] m_addr [4];
        logic [1:0]  m_size [4];
        int start, lat, strobes;
        bit got;
        m_dat[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 32'h1001; m_size[0] = 2'b10;
        m_dat[1] = 1'b1; m_we[1] = 1'b0; m_addr[1] = 32'h1003; m_size[1] = 2'b01;
        m_dat[2] = 1'b1; m_we[2] = 1'b1; m_addr[2] = 32'h1002; m_size[2] = 2'b10;
        m_dat[3] = 1'b0; m_we[3] = 1'b0; m_addr[3] = 32'h0102; m_size[3] = 2'b10;
        rd_word = 32'hFFFFFFFF;
        for (int t = 0; t < 4; t++) begin
            @(posedge clk); #1;
            sb.push_back('{m_dat[t], 1'b1, 32'h0, 1'b1});
            if (m_dat[t]) begin
                data_addr = m_addr[t]; data_size = m_size[t]; data_we = m_we[t];
                data_wdata = 32'h55555555; data_req = 1'b1;
            end else begin
                instr_addr = m_addr[t]; instr_req = 1'b1;
            end
            start = cyc; lat = -1; strobes = 0; got = 0;
            for (int i = 0; i < 10 && !got; i++) begin
                @(negedge clk);
                if (read || write) strobes++;
                if (instr_ready || data_ready) begin
                    got = 1; lat = cyc - start; instr_req = 1'b0; data_req = 1'b0;
                end
            end
            checks++;
            if (strobes != 0 || lat != 1) begin
                failures++;
                $display("FAIL misaligned_%0d strobes=%0d lat=%0d required strobes=0 lat=1", t, strobes, lat);
            end
        end
        data_we = 1'b0;
    endtask

    task automatic test_timeout();
        int start, lat, strobes;
        bit got;
        wait_target = 1000;
        @(posedge clk); #1;
        sb.push_back('{1'b1, 1'b1, 32'h0, 1'b1});
        data_addr = 32'h3000; data_size = 2'b10; data_we = 1'b0; data_req = 1'b1;
        start = cyc; lat = -1; strobes = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (read) strobes++;
            if (data_ready) begin got = 1; lat = cyc - start; data_req = 1'b0; end
        end
        checks++;
        if (strobes != 4) begin failures++; $display("FAIL timeout_strobes got=%0d required=4", strobes); end
        checks++;
        if (lat != 5) begin failures++; $display("FAIL timeout_latency got=%0d required=5", lat); end
        @(negedge clk);
        checks++;
        if (read !== 1'b0) begin failures++; $display("FAIL timeout_strobe_drop read=%b required=0", read); end
        wait_target = 0;
    endtask

    task automatic test_reset_mid();
        int strobes, start, lat;
        bit got;
        wait_target = 1000;
        @(posedge clk); #1;
        data_addr = 32'h4000; data_size = 2'b10; data_we = 1'b0; data_req = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (read !== 1'b1) begin failures++; $display("FAIL midreset_pre read=%b required=1", read); end
        reset = 1'b1;
        data_req = 1'b0;
        @(negedge clk);
        checks++;
        if (read !== 1'b0 || data_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_drop read=%b data_ready=%b required 0/0", read, data_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        wait_target = 0;
        strobes = 0;
        repeat (4) begin
            @(negedge clk);
            if (read || write || data_ready || instr_ready) strobes++;
        end
        checks++;
        if (strobes != 0) begin failures++; $display("FAIL midreset_quiet activity=%0d required=0", strobes); end
        // A fresh fetch must start from IDLE with nominal latency.
        rd_word = 32'hCAFE0001;
        @(posedge clk); #1;
        sb.push_back('{1'b0, 1'b1, 32'hCAFE0001, 1'b0});
        instr_addr = 32'h0000_0040; instr_req = 1'b1;
        start = cyc; lat = -1; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (instr_ready) begin got = 1; lat = cyc - start; instr_req = 1'b0; end
        end
        checks++;
        if (lat != 2) begin failures++; $display("FAIL midreset_recover lat=%0d required=2", lat); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_store_byte_wait();
        test_stores();
        test_loads();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_cpu_mem_arbiter.md
MIPS_CPU_MEM_ARBITER -- requirements
Module: mips_cpu_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of all address ports.
REQ-002 SHALL have parameter DATA_PRIORITY, default 1; 1 = data port wins simultaneous requests, 0 = instruction port wins.
REQ-003 SHALL have parameter STALL_LIMIT, default 0; consecutive waitrequest cycles before timeout, 0 = timeout disabled.
REQ-004 SHALL have ports in this order, with clock and reset first:
  clk  in  1  clock; reset: synchronous, active-high, named reset
  reset  in  1  synchronous active-high reset
  instr_req  in  1  fetch request, held until instr_ready
  instr_addr  in  ADDR_WIDTH  fetch byte address
  instr_ready  out  1  one-cycle fetch completion pulse
  instr_rdata  out  32  fetched word, valid with instr_ready
  data_req  in  1  load/store request, held until data_ready
  data_we  in  1  1 = store, 0 = load
  data_addr  in  ADDR_WIDTH  load/store byte address
  data_size  in  2  00 = byte, 01 = half, 10 = word
  data_unsigned  in  1  zero-extend loads (LBU/LHU)
  data_wdata  in  32  store data, right-justified
  data_ready  out  1  one-cycle load/store completion pulse
  data_rdata  out  32  extended load result, valid with data_ready
  err  out  1  error flag, valid with either ready pulse
  address  out  ADDR_WIDTH  bus word address, bits [1:0] = 0
  read  out  1  bus read strobe
  write  out  1  bus write strobe
  byteenable  out  4  bus byte lanes, bit n = byte n, little-endian
  writedata  out  32  bus write data
  waitrequest  in  1  slave stall
  readdata  in  32  bus read data

Function
REQ-005 SHALL implement the states IDLE, IREAD, DREAD, DWRITE and RESP.
REQ-006 In IDLE, a sampled request SHALL move to IREAD, DREAD or DWRITE per port and data_we; on simultaneous requests, DATA_PRIORITY selects; the losing request stays pending.
REQ-007 Address, byteenable and writedata SHALL be registered at acceptance and held constant until the transaction completes.
REQ-008 read/write SHALL be high throughout the bus state; the transaction SHALL complete on the edge where the strobe is high and waitrequest is low; readdata SHALL be captured on that edge.
REQ-009 After completion, the FSM SHALL enter RESP for exactly one cycle: the ready for the owning port = 1, err = 0; then it returns to IDLE.
REQ-010 Latency: with zero wait states, ready SHALL be high 2 cycles after the request is sampled; each waitrequest cycle adds 1; back-to-back throughput is 3 cycles per access.
REQ-011 Byte access SHALL use byteenable = 1<<addr[1:0] and writedata = wdata[7:0] replicated x4.
REQ-012 Half access SHALL use byteenable 0011 (addr[1]=0) or 1100 (addr[1]=1) and writedata = wdata[15:0] replicated x2.
REQ-013 Word access SHALL use byteenable 1111; instruction fetches are always word accesses.
REQ-014 Loads SHALL shift the selected lanes to bit 0 and then extend: sign-extend from bit 7/15, or zero-extend if data_unsigned.
REQ-015 A misaligned request (half with addr[0]=1; word with addr[1:0]!=0, including fetches) SHALL issue no bus cycle and SHALL go directly to RESP with err = 1 and rdata = 0.
REQ-016 If STALL_LIMIT>0 and waitrequest stays high for STALL_LIMIT consecutive strobe cycles, the strobe SHALL drop, and the FSM SHALL enter RESP with err = 1 and rdata = 0.
REQ-017 The stall counter SHALL clear on entry to each bus state and SHALL saturate without wrapping.
REQ-018 read and write SHALL never be high simultaneously; at most one ready pulses per cycle.
REQ-019 A requester deasserting req before ready is illegal; the behaviour is undefined and is not checked.

Reset
REQ-020 On reset, the FSM SHALL go to IDLE; read, write, instr_ready, data_ready and err = 0; byteenable = 0; address, writedata, instr_rdata and data_rdata = 0; stall counter = 0.
REQ-021 Reset mid-transaction SHALL drop the strobe on the next edge, with no ready pulse for the aborted request.

Verification
REQ-022 Fetch 0xBFC00000, waitrequest 0, readdata 0x24020005 -> read high 1 cycle, instr_ready at cycle +2, instr_rdata 0x24020005.
REQ-023 Simultaneous instr_req and data_req load, DATA_PRIORITY=1 -> data served first, then the fetch; two ready pulses 3 cycles apart.
REQ-024 SB addr 0x1003, wdata 0x000000AB, waitrequest high 3 cycles -> byteenable 1000, writedata 0xABABABAB held 4 cycles, data_ready at +5.
REQ-025 LH addr 0x1002, readdata 0x80FF1234 -> byteenable 1100, data_rdata 0xFFFF80FF; LHU -> 0x000080FF.
REQ-026 LW addr 0x1001 -> no strobe, data_ready with err=1; with STALL_LIMIT=4 and waitrequest stuck high -> strobe drops after 4 cycles, err=1.
REQ-027 Reset asserted during a waitrequest stall -> read low the next cycle, FSM in IDLE, no ready pulse.
